// File: rtl/iob_requester.sv
// iob_requester: CPU-side initiator for the I/O bus slave port. It launches one CPU I/O access
//   at a time to the PDS bus master as IORDREQ/IOWRREQ with lanes, then tracks the
//   IOACT/IODONE/IOBERR handshake and returns a one-cycle CPUACK (+CPUBERR).
// Latency: ALE one cycle after accept; IO*REQ one cycle after that; minimum CPUREQ->CPUACK ~7 cycles.
// Backpressure: one access outstanding; CPUREQ is held until CPUACK; a new access is taken only
//   in IDLE and only after CPUREQ has been seen low since the last CPUACK (ARM flag).
// Ports:
//   CLK, nRES                      clock, synchronous active-low reset
//   CPUREQ/CPURnW/CPULDS/CPUUDS    CPU access request, direction and byte lanes
//   CPUACK/CPUBERR/RDLE/ALE/BUSY   CPU-side completion, error, latch strobes, busy
//   IORDREQ/IOWRREQ/IOLDS/IOUDS    request to the bus master
//   IOACT/IODONE/IOBERR            asynchronous master status (2-flop synchronized)
// Build option: define IOB_POSTWR_EN to acknowledge writes at ALE time (posted writes).
module iob_requester #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRES,
  input  logic CPUREQ,
  input  logic CPURnW,
  input  logic CPULDS,
  input  logic CPUUDS,
  output logic CPUACK,
  output logic CPUBERR,
  output logic ALE,
  output logic RDLE,
  output logic BUSY,
  output logic IORDREQ,
  output logic IOWRREQ,
  output logic IOLDS,
  output logic IOUDS,
  input  logic IOACT,
  input  logic IODONE,
  input  logic IOBERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_REQ,
    S_DRAIN,
    S_ACK
  } state_t;

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] sync1_q, sync2_q;  // {BERR, DONE, ACT}
  logic       rnw_q, rnw_d;
  logic       lds_q, lds_d;
  logic       uds_q, uds_d;
  logic       err_q, err_d;
  logic       posted_q, posted_d;
  logic       arm_q, arm_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       berr_q, berr_d;
  logic       ale_q, ale_d;
  logic       rdle_q, rdle_d;
  logic       rdreq_q, rdreq_d;
  logic       wrreq_q, wrreq_d;
  logic       iolds_q, iolds_d;
  logic       iouds_q, iouds_d;

  logic       acts, dones, berrs;
  logic       accept;
  logic [7:0] cnt_inc;

  assign acts  = sync2_q[0];
  assign dones = sync2_q[1];
  assign berrs = sync2_q[2];

  assign accept = (state_q == S_IDLE) && CPUREQ && arm_q;

  always_comb begin
    state_d  = state_q;
    rnw_d    = rnw_q;
    lds_d    = lds_q;
    uds_d    = uds_q;
    err_d    = err_q;
    posted_d = posted_q;
    cnt_d    = cnt_q;
    rdreq_d  = rdreq_q;
    wrreq_d  = wrreq_q;
    iolds_d  = iolds_q;
    iouds_d  = iouds_q;
    ack_d    = 1'b0;
    berr_d   = 1'b0;
    ale_d    = 1'b0;
    rdle_d   = 1'b0;
    cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // ARM re-opens only after CPUREQ has been seen low outside the ACK cycle,
    // so a request still held from the previous access is never taken twice.
    if (ack_q)        arm_d = 1'b0;
    else if (!CPUREQ) arm_d = 1'b1;
    else              arm_d = arm_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rnw_d    = CPURnW;
          lds_d    = CPULDS;
          uds_d    = CPUUDS;
          err_d    = 1'b0;
          posted_d = 1'b0;
          ale_d    = 1'b1;
          state_d  = S_LAUNCH;
`ifdef IOB_POSTWR_EN
          if (!CPURnW) begin
            posted_d = 1'b1;
            ack_d    = 1'b1;
          end
`endif
        end
      end
      S_LAUNCH: begin
        rdreq_d = rnw_q;
        wrreq_d = !rnw_q;
        iolds_d = lds_q;
        iouds_d = uds_q;
        cnt_d   = 8'd0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (dones || berrs) begin
          // Drop the request on DONE, ahead of IOACT falling, so the
          // master returns to idle without seeing a stale request.
          rdreq_d = 1'b0;
          wrreq_d = 1'b0;
          iolds_d = 1'b0;
          iouds_d = 1'b0;
          err_d   = berrs;
          state_d = S_DRAIN;
        end else if (!acts) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_VAL) begin
            rdreq_d = 1'b0;
            wrreq_d = 1'b0;
            iolds_d = 1'b0;
            iouds_d = 1'b0;
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!acts) begin
          state_d = S_ACK;
          // A posted write was already acknowledged; its outcome is dropped.
          if (!posted_q) begin
            ack_d  = 1'b1;
            berr_d = err_q;
            rdle_d = rnw_q && !err_q;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRES) begin
      state_q  <= S_IDLE;
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      rnw_q    <= 1'b0;
      lds_q    <= 1'b0;
      uds_q    <= 1'b0;
      err_q    <= 1'b0;
      posted_q <= 1'b0;
      arm_q    <= 1'b0;
      cnt_q    <= 8'd0;
      ack_q    <= 1'b0;
      berr_q   <= 1'b0;
      ale_q    <= 1'b0;
      rdle_q   <= 1'b0;
      rdreq_q  <= 1'b0;
      wrreq_q  <= 1'b0;
      iolds_q  <= 1'b0;
      iouds_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= {IOBERR, IODONE, IOACT};
      sync2_q  <= sync1_q;
      rnw_q    <= rnw_d;
      lds_q    <= lds_d;
      uds_q    <= uds_d;
      err_q    <= err_d;
      posted_q <= posted_d;
      arm_q    <= arm_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      berr_q   <= berr_d;
      ale_q    <= ale_d;
      rdle_q   <= rdle_d;
      rdreq_q  <= rdreq_d;
      wrreq_q  <= wrreq_d;
      iolds_q  <= iolds_d;
      iouds_q  <= iouds_d;
    end
  end

  assign CPUACK  = ack_q;
  assign CPUBERR = berr_q;
  assign ALE     = ale_q;
  assign RDLE    = rdle_q;
  assign IORDREQ = rdreq_q;
  assign IOWRREQ = wrreq_q;
  assign IOLDS   = iolds_q;
  assign IOUDS   = iouds_q;
  // The IDLE cycle that accepts a held request already counts as busy, so a
  // request queued behind a posted write sees BUSY without a gap.
  assign BUSY    = (state_q != S_IDLE) || accept;

endmodule
